// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy states, legacy
// stall codes and a helper that maps a state to its entry count.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // Codes of the old three-way stall port, kept for wrappers around legacy latches.
  localparam logic [1:0] STALL_NEXT = 2'd0;
  localparam logic [1:0] STALL_KEEP = 2'd1;
  localparam logic [1:0] STALL_ZERO = 2'd2;

  localparam int DEFAULT_DATA_W = 256;

  function automatic logic [1:0] occupancy(input logic [1:0] st);
    logic [1:0] n;
    case (st)
      ST_ONE:  n = 2'd1;
      ST_TWO:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by rst only.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register with valid/ready handshake, flush and an
// optional skid entry that makes in_ready a pure flop output.
//
// Handshake: a beat moves on a rising edge when valid & ready are both high;
// a producer holding valid keeps its data stable until that edge, and valid
// never depends on ready on the same side.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int SKID          = 1,
  parameter int ZERO_ON_FLUSH = 1,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_EMPTY = ST_EMPTY;
  localparam logic [1:0] S_ONE   = ST_ONE;
  localparam logic [1:0] S_TWO   = ST_TWO;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [1:0]        count_q, count_d;
  logic              in_ready_q, in_ready_d;

  logic main_valid;
  logic accept;
  logic send;
  logic stall_inc;

  assign main_valid = (state_q != S_EMPTY);
  assign out_valid  = main_valid & ~flush;
  assign out_data   = main_q;
  assign count      = count_q;
  assign dbg_state  = state_q;

  // Without a skid entry the stage can only take a beat while the old one leaves.
  assign in_ready = (SKID != 0) ? in_ready_q : (out_ready | ~main_valid);

  assign accept    = in_valid & in_ready;
  assign send      = out_valid & out_ready;
  assign stall_inc = out_valid & ~out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      if (ZERO_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_data;
          end
        end
        S_ONE: begin
          if (accept && send) begin
            main_d = in_data;
          end else if (accept && (SKID != 0)) begin
            state_d = S_TWO;
            skid_d  = in_data;
          end else if (send) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only the drain of the main entry matters.
          if (send) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    count_d    = occupancy(state_d);
    in_ready_d = (state_d != S_TWO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .q   (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid stage with zeroing flush (a),
// skid stage with retaining flush and 3-bit stall counter (b), no-skid stage (c).
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       c_flush, c_in_valid, c_out_ready;
  logic [7:0] c_in_data;

  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_data;
  logic [1:0]  a_count, a_dbg;
  logic [31:0] a_stall;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_count, b_dbg;
  logic [2:0]  b_stall;
  logic        c_in_ready, c_out_valid;
  logic [7:0]  c_out_data;
  logic [1:0]  c_count, c_dbg;
  logic [31:0] c_stall;

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .count(a_count), .stall_cycles(a_stall), .dbg_state(a_dbg));

  pipe_stage_reg #(.DATA_W(8), .SKID(1), .ZERO_ON_FLUSH(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .count(b_count), .stall_cycles(b_stall), .dbg_state(b_dbg));

  pipe_stage_reg #(.DATA_W(8), .SKID(0), .ZERO_ON_FLUSH(1), .CNT_W(32)) dut_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .count(c_count), .stall_cycles(c_stall), .dbg_state(c_dbg));

  // Upstream must hold valid and data until accepted (flush and reset release it).
  logic       a_pend = 1'b0, c_pend = 1'b0;
  logic [7:0] a_pend_d = '0, c_pend_d = '0;
  always @(posedge clk) begin
    if (a_pend && !rst && !flush)
      assert (in_valid && in_data == a_pend_d) else $error("upstream hold broken on a/b");
    if (c_pend && !rst && !c_flush)
      assert (c_in_valid && c_in_data == c_pend_d) else $error("upstream hold broken on c");
    a_pend   <= in_valid && !a_in_ready && !rst && !flush;
    a_pend_d <= in_data;
    c_pend   <= c_in_valid && !c_in_ready && !rst && !c_flush;
    c_pend_d <= c_in_data;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    c_flush = 1'b0; c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
    #2;
    total++;
    if ({a_out_valid, a_out_data, a_count, a_in_ready, a_stall} !== {1'b0, 8'h00, 2'd0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL reset_a got v=%b d=%h n=%0d rdy=%b st=%0d want 0/00/0/1/0", a_out_valid, a_out_data, a_count, a_in_ready, a_stall);
    end
    total++;
    if ({b_out_valid, b_out_data, b_count, b_in_ready, b_stall} !== {1'b0, 8'h00, 2'd0, 1'b1, 3'd0}) begin
      bad++; $display("FAIL reset_b got v=%b d=%h n=%0d rdy=%b st=%0d want 0/00/0/1/0", b_out_valid, b_out_data, b_count, b_in_ready, b_stall);
    end
    total++;
    if ({c_out_valid, c_out_data, c_count, c_in_ready, c_stall} !== {1'b0, 8'h00, 2'd0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL reset_c got v=%b d=%h n=%0d rdy=%b st=%0d want 0/00/0/1/0", c_out_valid, c_out_data, c_count, c_in_ready, c_stall);
    end
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      cyc;
      total++;
      if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b1, 8'(i), 2'd1, 1'b1}) begin
        bad++; $display("FAIL stream_a[%0d] got v=%b d=%h n=%0d rdy=%b want 1/%h/1/1", i, a_out_valid, a_out_data, a_count, a_in_ready, 8'(i));
      end
      total++;
      if ({b_out_valid, b_out_data, b_count} !== {1'b1, 8'(i), 2'd1}) begin
        bad++; $display("FAIL stream_b[%0d] got v=%b d=%h n=%0d want 1/%h/1", i, b_out_valid, b_out_data, b_count, 8'(i));
      end
    end
    in_valid = 1'b0;
    cyc;
    total++;
    if ({a_out_valid, a_count, a_stall} !== {1'b0, 2'd0, 32'd0}) begin
      bad++; $display("FAIL stream_end got v=%b n=%0d st=%0d want 0/0/0", a_out_valid, a_count, a_stall);
    end
  endtask

  task automatic test_skid;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h0A;
    cyc;
    in_data = 8'h0B;
    cyc;
    in_data = 8'h0C;
    cyc;
    total++;
    if ({a_out_data, a_count, a_in_ready, b_in_ready} !== {8'h0A, 2'd2, 1'b0, 1'b0}) begin
      bad++; $display("FAIL skid_full got d=%h n=%0d rdy=%b/%b want 0a/2/0/0", a_out_data, a_count, a_in_ready, b_in_ready);
    end
    out_ready = 1'b1;
    cyc;
    total++;
    if ({a_out_valid, a_out_data, a_count, a_in_ready} !== {1'b1, 8'h0B, 2'd1, 1'b1}) begin
      bad++; $display("FAIL skid_pop_b got v=%b d=%h n=%0d rdy=%b want 1/0b/1/1", a_out_valid, a_out_data, a_count, a_in_ready);
    end
    cyc;
    in_valid = 1'b0;
    total++;
    if ({a_out_valid, a_out_data, b_out_data, a_count} !== {1'b1, 8'h0C, 8'h0C, 2'd1}) begin
      bad++; $display("FAIL skid_pop_c got v=%b d=%h/%h n=%0d want 1/0c/0c/1", a_out_valid, a_out_data, b_out_data, a_count);
    end
    cyc;
    total++;
    if ({a_out_valid, a_count} !== {1'b0, 2'd0}) begin
      bad++; $display("FAIL skid_drain got v=%b n=%0d want 0/0", a_out_valid, a_count);
    end
  endtask

  task automatic test_stall_sat;
    rst = 1'b1;
    cyc;
    rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    cyc;
    in_data = 8'h02;
    cyc;
    in_valid = 1'b0;
    repeat (4) cyc;
    total++;
    if ({a_stall, b_stall, a_count} !== {32'd5, 3'd5, 2'd2}) begin
      bad++; $display("FAIL stall_5 got a=%0d b=%0d n=%0d want 5/5/2", a_stall, b_stall, a_count);
    end
    repeat (5) cyc;
    total++;
    if ({a_stall, b_stall, a_out_data} !== {32'd10, 3'd7, 8'h01}) begin
      bad++; $display("FAIL stall_sat got a=%0d b=%0d d=%h want 10/7/01", a_stall, b_stall, a_out_data);
    end
  endtask

  task automatic test_flush;
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h0D;
    #1;
    total++;
    if ({a_out_valid, b_out_valid} !== 2'b00) begin
      bad++; $display("FAIL flush_gate got va=%b vb=%b want 0/0", a_out_valid, b_out_valid);
    end
    cyc;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({a_out_valid, a_count, a_in_ready, a_out_data, a_stall} !== {1'b0, 2'd0, 1'b1, 8'h00, 32'd10}) begin
      bad++; $display("FAIL flush_a got v=%b n=%0d rdy=%b d=%h st=%0d want 0/0/1/00/10", a_out_valid, a_count, a_in_ready, a_out_data, a_stall);
    end
    total++;
    if ({b_out_valid, b_count, b_in_ready, b_out_data, b_stall} !== {1'b0, 2'd0, 1'b1, 8'h01, 3'd7}) begin
      bad++; $display("FAIL flush_b got v=%b n=%0d rdy=%b d=%h st=%0d want 0/0/1/01/7", b_out_valid, b_count, b_in_ready, b_out_data, b_stall);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h03;
    cyc;
    flush = 1'b1; in_data = 8'h0E;
    cyc;
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({a_out_valid, a_count, a_out_data, b_out_data} !== {1'b0, 2'd0, 8'h00, 8'h03}) begin
      bad++; $display("FAIL flush_accept got v=%b n=%0d d=%h/%h want 0/0/00/03", a_out_valid, a_count, a_out_data, b_out_data);
    end
    for (int k = 0; k < 3; k++) begin
      cyc;
      total++;
      if ({a_out_valid, b_out_valid} !== 2'b00) begin
        bad++; $display("FAIL flush_ghost[%0d] got va=%b vb=%b want 0/0", k, a_out_valid, b_out_valid);
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h01;
    cyc;
    in_data = 8'h02;
    cyc;
    in_valid = 1'b0;
    total++;
    if (a_count !== 2'd2) begin
      bad++; $display("FAIL rstmid_pre got n=%0d want 2", a_count);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_out_valid, a_out_data, a_count, a_in_ready, a_stall} !== {1'b0, 8'h00, 2'd0, 1'b1, 32'd0}) begin
      bad++; $display("FAIL rstmid_a got v=%b d=%h n=%0d rdy=%b st=%0d want 0/00/0/1/0", a_out_valid, a_out_data, a_count, a_in_ready, a_stall);
    end
    total++;
    if ({b_out_valid, b_out_data, b_count, b_stall} !== {1'b0, 8'h00, 2'd0, 3'd0}) begin
      bad++; $display("FAIL rstmid_b got v=%b d=%h n=%0d st=%0d want 0/00/0/0", b_out_valid, b_out_data, b_count, b_stall);
    end
    cyc;
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h05;
    cyc;
    in_valid = 1'b0;
    total++;
    if ({a_out_valid, a_out_data, a_count} !== {1'b1, 8'h05, 2'd1}) begin
      bad++; $display("FAIL rstmid_post got v=%b d=%h n=%0d want 1/05/1", a_out_valid, a_out_data, a_count);
    end
    cyc;
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_drain got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_no_skid;
    c_in_valid = 1'b1; c_in_data = 8'h21; c_out_ready = 1'b0;
    #1;
    total++;
    if (c_in_ready !== 1'b1) begin
      bad++; $display("FAIL noskid_empty_rdy got %b want 1", c_in_ready);
    end
    cyc;
    c_in_data = 8'h22;
    #1;
    total++;
    if ({c_in_ready, c_out_data, c_count} !== {1'b0, 8'h21, 2'd1}) begin
      bad++; $display("FAIL noskid_full got rdy=%b d=%h n=%0d want 0/21/1", c_in_ready, c_out_data, c_count);
    end
    c_out_ready = 1'b1;
    #1;
    total++;
    if (c_in_ready !== 1'b1) begin
      bad++; $display("FAIL noskid_follow_hi got %b want 1", c_in_ready);
    end
    cyc;
    c_out_ready = 1'b0; c_in_data = 8'h23;
    #1;
    total++;
    if ({c_in_ready, c_out_data} !== {1'b0, 8'h22}) begin
      bad++; $display("FAIL noskid_follow_lo got rdy=%b d=%h want 0/22", c_in_ready, c_out_data);
    end
    cyc;
    total++;
    if ({c_out_valid, c_out_data, c_count} !== {1'b1, 8'h22, 2'd1}) begin
      bad++; $display("FAIL noskid_hold got v=%b d=%h n=%0d want 1/22/1", c_out_valid, c_out_data, c_count);
    end
    c_out_ready = 1'b1;
    cyc;
    c_in_valid = 1'b0;
    total++;
    if ({c_out_valid, c_out_data} !== {1'b1, 8'h23}) begin
      bad++; $display("FAIL noskid_last got v=%b d=%h want 1/23", c_out_valid, c_out_data);
    end
    cyc;
    total++;
    if ({c_out_valid, c_count, c_stall} !== {1'b0, 2'd0, 32'd1}) begin
      bad++; $display("FAIL noskid_end got v=%b n=%0d st=%0d want 0/0/1", c_out_valid, c_count, c_stall);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_stream;
    test_skid;
    test_stall_sat;
    test_flush;
    test_reset_mid;
    test_no_skid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
